// File: rtl/vertex_feeder.sv
// vertex_feeder: streams BRAM vertices into matrix_mult as (x,y,z,1.0) and buffers results in a FWFT FIFO.
// Defining VERTEX_FEEDER_STALL_CNT_EN adds stall_cnt_out, a saturating count of stalled output cycles.
module vertex_feeder #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [15:0]       vertex_count_in,
    output logic [ADDR_W-1:0] vtx_addr_out,
    input  logic [95:0]       vtx_data_in,
    output logic              mm_valid_out,
    output logic [127:0]      mm_vec_out,
    input  logic              mm_valid_in,
    input  logic [127:0]      mm_vec_in,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [127:0]      out_data_out,
    output logic              out_last_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
`ifdef VERTEX_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_out
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_W-1:0]       r_base;
    logic [15:0]             r_count;
    logic [15:0]             r_issued;
    logic [15:0]             r_popped;
    logic [CNT_W-1:0]        r_in_flight;
    logic [CNT_W-1:0]        w_in_flight_next;
    logic [READ_LATENCY-1:0] r_valid_sr;
    logic [127:0]            r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fill;
    logic                    r_error;
    logic                    r_done;

    logic w_start, w_issue, w_capture, w_push, w_overflow, w_pop, w_empty, w_full;

    assign w_start    = (r_state == S_IDLE) && start_in;
    assign w_issue    = (r_state == S_RUN) && (r_issued < r_count)
                        && (r_in_flight < CNT_W'(FIFO_DEPTH));
    assign w_capture  = mm_valid_in && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_empty    = (r_fill == '0);
    assign w_full     = (r_fill == CNT_W'(FIFO_DEPTH));
    assign w_push     = w_capture && !w_full;
    assign w_overflow = w_capture && w_full;
    assign w_pop      = !w_empty && out_ready_in;

    // Guarded decrement keeps the credit count sane if a rogue producer pushes unrequested results.
    always_comb begin
        w_in_flight_next = r_in_flight;
        if (w_issue && !w_pop) begin
            w_in_flight_next = r_in_flight + CNT_W'(1);
        end else if (!w_issue && w_pop && (r_in_flight != '0)) begin
            w_in_flight_next = r_in_flight - CNT_W'(1);
        end
    end

    // DRAIN leaves on the edge that retires the last outstanding vertex.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_next_state = (vertex_count_in == 16'd0) ? S_DONE : S_RUN;
            S_RUN:   if (r_issued == r_count) w_next_state = S_DRAIN;
            S_DRAIN: if (w_in_flight_next == '0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_in_flight <= '0;
            r_valid_sr  <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_flight <= w_in_flight_next;
            r_valid_sr  <= (r_valid_sr << 1) | READ_LATENCY'(w_issue);
            r_done      <= (r_state == S_DONE);
            if (w_overflow) r_error <= 1'b1;
            if (w_start) begin
                r_base   <= base_addr_in;
                r_count  <= vertex_count_in;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue) r_issued <= r_issued + 16'd1;
                if (w_pop)   r_popped <= r_popped + 16'd1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_fill <= r_fill + CNT_W'(1);
            else if (!w_push && w_pop) r_fill <= r_fill - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= mm_vec_in;
    end

`ifdef VERTEX_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || w_start) begin
            r_stall_cnt <= '0;
        end else if (!w_empty && !out_ready_in && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_out = r_stall_cnt;
`endif

    assign vtx_addr_out  = (r_state == S_RUN) ? (r_base + ADDR_W'(r_issued)) : '0;
    assign mm_valid_out  = r_valid_sr[READ_LATENCY-1];
    assign mm_vec_out    = mm_valid_out ? {32'h0001_0000, vtx_data_in} : '0;
    assign out_valid_out = !w_empty;
    assign out_data_out  = w_empty ? '0 : r_fifo_mem[r_rd_ptr];
    assign out_last_out  = !w_empty && (r_popped == (r_count - 16'd1));
    assign busy_out      = (r_state != S_IDLE);
    assign done_out      = r_done;
    assign error_out     = r_error;

endmodule

// File: tb/tb_vertex_feeder.sv
// tb_vertex_feeder: directed bench for vertex_feeder with a BRAM model and a 4-cycle identity matrix_mult model.
`timescale 1ns/1ps
module tb_vertex_feeder;
    localparam int ADDR_W       = 12;
    localparam int READ_LATENCY = 2;
    localparam int FIFO_DEPTH   = 8;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              start_in = 1'b0;
    logic [ADDR_W-1:0] base_addr_in = '0;
    logic [15:0]       vertex_count_in = '0;
    logic [ADDR_W-1:0] vtx_addr_out;
    logic [95:0]       vtx_data_in = '0;
    logic              mm_valid_out;
    logic [127:0]      mm_vec_out;
    logic              mm_valid_in;
    logic [127:0]      mm_vec_in;
    logic              out_valid_out;
    logic              out_ready_in = 1'b0;
    logic [127:0]      out_data_out;
    logic              out_last_out;
    logic              busy_out;
    logic              done_out;
    logic              error_out;
`ifdef VERTEX_FEEDER_STALL_CNT_EN
    logic [31:0]       stallCnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int startCycle = 0;

    vertex_feeder #(.ADDR_W(ADDR_W), .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .base_addr_in(base_addr_in), .vertex_count_in(vertex_count_in),
        .vtx_addr_out(vtx_addr_out), .vtx_data_in(vtx_data_in),
        .mm_valid_out(mm_valid_out), .mm_vec_out(mm_vec_out),
        .mm_valid_in(mm_valid_in), .mm_vec_in(mm_vec_in),
        .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .out_data_out(out_data_out), .out_last_out(out_last_out),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
`ifdef VERTEX_FEEDER_STALL_CNT_EN
        , .stall_cnt_out(stallCnt)
`endif
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // BRAM model: address registered, then data registered, giving two cycles of read latency.
    logic [95:0]       bram [4096];
    logic [ADDR_W-1:0] bramAddrQ = '0;
    always @(posedge clk_in) begin
        bramAddrQ   <= vtx_addr_out;
        vtx_data_in <= bram[bramAddrQ];
    end

    function automatic logic [95:0] vdata(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x + 32'h2000, x + 32'h1000, x};
    endfunction

    // Identity matrix_mult with four cycles of latency; rogue pulses can be injected alongside.
    logic         mmEn = 1'b1;
    logic [3:0]   mmV = '0;
    logic [127:0] mmD [4];
    logic         rogueValid = 1'b0;
    logic [127:0] rogueVec = '0;
    always @(posedge clk_in) begin
        mmV     <= {mmV[2:0], mm_valid_out && mmEn};
        mmD[0]  <= mm_vec_out;
        mmD[1]  <= mmD[0];
        mmD[2]  <= mmD[1];
        mmD[3]  <= mmD[2];
    end
    assign mm_valid_in = mmV[3] | rogueValid;
    assign mm_vec_in   = rogueValid ? rogueVec : mmD[3];

    // Monitor records issued addresses, accepted outputs and done pulses at the falling edge.
    logic [ADDR_W-1:0] addrHist [READ_LATENCY+1];
    logic [ADDR_W-1:0] issuedAddrQ [$];
    logic [127:0]      mmVecQ [$];
    logic [127:0]      popDataQ [$];
    logic              popLastQ [$];
    int                doneCount = 0;
    int                doneCycle = -1;
    int                lastPopCycle = -1;
    bit                addrSeen = 1'b0;
    bit                validSeen = 1'b0;

    always @(negedge clk_in) begin
        for (int i = READ_LATENCY; i > 0; i--) addrHist[i] = addrHist[i-1];
        addrHist[0] = vtx_addr_out;
        if (vtx_addr_out !== '0) addrSeen = 1'b1;
        if (out_valid_out) validSeen = 1'b1;
        if (mm_valid_out) begin
            issuedAddrQ.push_back(addrHist[READ_LATENCY]);
            mmVecQ.push_back(mm_vec_out);
        end
        if (out_valid_out && out_ready_in) begin
            popDataQ.push_back(out_data_out);
            popLastQ.push_back(out_last_out);
            lastPopCycle = cyc;
        end
        if (done_out) begin
            doneCount++;
            doneCycle = cyc;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clearMon();
        issuedAddrQ.delete();
        mmVecQ.delete();
        popDataQ.delete();
        popLastQ.delete();
        doneCount = 0;
        doneCycle = -1;
        lastPopCycle = -1;
        addrSeen = 1'b0;
        validSeen = 1'b0;
    endtask

    task automatic startPass(input logic [ADDR_W-1:0] base, input logic [15:0] count);
        base_addr_in    = base;
        vertex_count_in = count;
        start_in        = 1'b1;
        startCycle      = cyc;
        tick();
        start_in        = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy_out, done_out, error_out, out_valid_out, mm_valid_out, out_last_out} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {busy_out, done_out, error_out, out_valid_out, mm_valid_out, out_last_out});
        end
        checks++;
        if (vtx_addr_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addr: got %h expected 000", vtx_addr_out);
        end
        checks++;
        if ((out_data_out !== '0) || (mm_vec_out !== '0)) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h/%h expected 0", out_data_out, mm_vec_out);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [127:0] expData [3];
        expData[0] = {ONE, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        expData[1] = {ONE, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
        expData[2] = {ONE, 32'h0009_0000, 32'h0008_0000, 32'h0007_0000};
        clearMon();
        out_ready_in = 1'b1;
        mmEn = 1'b1;
        startPass(12'h010, 16'd3);
        for (int n = 0; n < 100 && doneCount == 0; n++) tick();
        tick();
        tick();
        checks++;
        if (doneCount != 1) begin
            failures++;
            $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy_after: got %b expected 0", busy_out);
        end
        checks++;
        if (popDataQ.size() != 3) begin
            failures++;
            $display("[TB] FAIL basic_out_count: got %0d expected 3", popDataQ.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= popDataQ.size() || popDataQ[i] !== expData[i]) begin
                failures++;
                $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i,
                         (i < popDataQ.size()) ? popDataQ[i] : 128'hx, expData[i]);
            end
            checks++;
            if (i >= popLastQ.size() || popLastQ[i] !== (i == 2)) begin
                failures++;
                $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i,
                         (i < popLastQ.size()) ? popLastQ[i] : 1'bx, (i == 2));
            end
            checks++;
            if (i >= issuedAddrQ.size() || issuedAddrQ[i] !== 12'h010 + 12'(i)) begin
                failures++;
                $display("[TB] FAIL basic_addr[%0d]: got %h expected %h", i,
                         (i < issuedAddrQ.size()) ? issuedAddrQ[i] : 12'hx, 12'h010 + 12'(i));
            end
        end
        checks++;
        if (mmVecQ.size() == 0 || mmVecQ[0] !== expData[0]) begin
            failures++;
            $display("[TB] FAIL basic_mm_vec: got %h expected %h",
                     (mmVecQ.size() > 0) ? mmVecQ[0] : 128'hx, expData[0]);
        end
        // done rises on the edge after the edge that accepts the final vertex
        checks++;
        if (doneCycle != lastPopCycle + 2) begin
            failures++;
            $display("[TB] FAIL basic_done_timing: got cycle %0d expected %0d", doneCycle, lastPopCycle + 2);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] expVal;
        clearMon();
        out_ready_in = 1'b0;
        startPass(12'h100, 16'd20);
        repeat (100) tick();
        checks++;
        if (issuedAddrQ.size() != FIFO_DEPTH) begin
            failures++;
            $display("[TB] FAIL bp_stalled_reads: got %0d expected %0d", issuedAddrQ.size(), FIFO_DEPTH);
        end
        checks++;
        if ({out_valid_out, busy_out, error_out} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL bp_stalled_flags: got %b expected 110", {out_valid_out, busy_out, error_out});
        end
        out_ready_in = 1'b1;
        for (int n = 0; n < 300 && doneCount == 0; n++) tick();
        tick();
        checks++;
        if (popDataQ.size() != 20) begin
            failures++;
            $display("[TB] FAIL bp_out_count: got %0d expected 20", popDataQ.size());
        end
        for (int i = 0; i < 20; i++) begin
            expVal = {ONE, vdata(12'h100 + 12'(i))};
            checks++;
            if (i >= popDataQ.size() || popDataQ[i] !== expVal || popLastQ[i] !== (i == 19)) begin
                failures++;
                $display("[TB] FAIL bp_data[%0d]: got %h expected %h last %b", i,
                         (i < popDataQ.size()) ? popDataQ[i] : 128'hx, expVal, (i == 19));
            end
        end
        checks++;
        if (error_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_error: got %b expected 0", error_out);
        end
    endtask

    task automatic test_zero_count();
        clearMon();
        startPass(12'h123, 16'd0);
        for (int n = 0; n < 10 && doneCount == 0; n++) tick();
        repeat (3) tick();
        checks++;
        if (doneCount != 1 || doneCycle != startCycle + 2) begin
            failures++;
            $display("[TB] FAIL zero_done: got count %0d cycle %0d expected 1 at %0d",
                     doneCount, doneCycle, startCycle + 2);
        end
        checks++;
        if (issuedAddrQ.size() != 0 || addrSeen) begin
            failures++;
            $display("[TB] FAIL zero_activity: got reads %0d addr_seen %b expected 0 0",
                     issuedAddrQ.size(), addrSeen);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] expAddr [4];
        expAddr[0] = 12'hFFE;
        expAddr[1] = 12'hFFF;
        expAddr[2] = 12'h000;
        expAddr[3] = 12'h001;
        clearMon();
        startPass(12'hFFE, 16'd4);
        for (int n = 0; n < 100 && doneCount == 0; n++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= issuedAddrQ.size() || issuedAddrQ[i] !== expAddr[i]) begin
                failures++;
                $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i,
                         (i < issuedAddrQ.size()) ? issuedAddrQ[i] : 12'hx, expAddr[i]);
            end
        end
        checks++;
        if (popDataQ.size() != 4 || popDataQ[3] !== {ONE, vdata(12'h001)}) begin
            failures++;
            $display("[TB] FAIL wrap_data: got %0d entries expected 4 ending %h", popDataQ.size(),
                     {ONE, vdata(12'h001)});
        end
    endtask

    task automatic test_reset_midpass();
        clearMon();
        out_ready_in = 1'b1;
        startPass(12'h040, 16'd3);
        for (int n = 0; n < 20 && issuedAddrQ.size() < 3; n++) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        validSeen = 1'b0;
        repeat (15) tick();
        checks++;
        if (validSeen || popDataQ.size() != 0 || doneCount != 0) begin
            failures++;
            $display("[TB] FAIL midreset_quiet: got valid %b pops %0d done %0d expected 0 0 0",
                     validSeen, popDataQ.size(), doneCount);
        end
        checks++;
        if ({busy_out, error_out} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midreset_flags: got %b expected 00", {busy_out, error_out});
        end
        clearMon();
        startPass(12'h010, 16'd3);
        for (int n = 0; n < 100 && doneCount == 0; n++) tick();
        checks++;
        if (popDataQ.size() != 3 || popDataQ[0] !== {ONE, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}
            || popLastQ[2] !== 1'b1 || doneCount != 1) begin
            failures++;
            $display("[TB] FAIL midreset_repass: got pops %0d done %0d expected 3 1", popDataQ.size(), doneCount);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [127:0] expVal;
        clearMon();
        mmEn = 1'b0;
        out_ready_in = 1'b0;
        startPass(12'h200, 16'd20);
        repeat (30) tick();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            rogueValid = 1'b1;
            rogueVec   = {96'hA5A5, 32'(i)};
            tick();
        end
        rogueValid = 1'b0;
        tick();
        checks++;
        if (error_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_error_set: got %b expected 1", error_out);
        end
        out_ready_in = 1'b1;
        for (int n = 0; n < 30 && popDataQ.size() < FIFO_DEPTH; n++) tick();
        repeat (20) tick();
        checks++;
        if (popDataQ.size() != FIFO_DEPTH) begin
            failures++;
            $display("[TB] FAIL ovf_count: got %0d expected %0d", popDataQ.size(), FIFO_DEPTH);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            expVal = {96'hA5A5, 32'(i)};
            checks++;
            if (i >= popDataQ.size() || popDataQ[i] !== expVal) begin
                failures++;
                $display("[TB] FAIL ovf_data[%0d]: got %h expected %h", i,
                         (i < popDataQ.size()) ? popDataQ[i] : 128'hx, expVal);
            end
        end
        checks++;
        if (error_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_error_sticky: got %b expected 1", error_out);
        end
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({error_out, out_valid_out, busy_out} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL ovf_reset_clear: got %b expected 000", {error_out, out_valid_out, busy_out});
        end
        rst_in = 1'b0;
        mmEn = 1'b1;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) bram[a] = vdata(ADDR_W'(a));
        bram[12'h010] = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        bram[12'h011] = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
        bram[12'h012] = {32'h0009_0000, 32'h0008_0000, 32'h0007_0000};
        for (int i = 0; i <= READ_LATENCY; i++) addrHist[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_reset_midpass();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vertex_feeder.md
Name: vertex_feeder

Overview:
- Initiator-side driver for `matrix_mult`.
- Streams a list of model-space vertices from a vertex BRAM into `matrix_mult` as 4-vectors (x, y, z, 1.0).
- Collects the transformed vectors into an internal FIFO and presents them on a ready/valid output stream to the downstream rasteriser.
- Sits between vertex memory and the `matrix_mult` result consumer. The transform matrix itself is wired to `matrix_mult` separately.

Parameters:
- ADDR_W, 12, vertex BRAM address width
- READ_LATENCY, 2, BRAM read latency in cycles (1..4)
- FIFO_DEPTH, 8, result FIFO entries (power of two, >= 2)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse: begin a pass
- base_addr_in  input  ADDR_W  address of first vertex
- vertex_count_in  input  16  number of vertices in the pass
- vtx_addr_out  output  ADDR_W  BRAM read address
- vtx_data_in  input  96  BRAM read data {z,y,x}, each 32-bit signed Q16.16
- mm_valid_out  output  1  vector valid to `matrix_mult`
- mm_vec_out  output  128  {w,z,y,x} to `matrix_mult`
- mm_valid_in  input  1  result valid from `matrix_mult`
- mm_vec_in  input  128  transformed {w,z,y,x}
- out_valid_out  output  1  result stream valid
- out_ready_in  input  1  downstream ready
- out_data_out  output  128  transformed vertex
- out_last_out  output  1  marks final vertex of pass
- busy_out  output  1  high outside IDLE
- done_out  output  1  one-cycle pulse at pass end
- error_out  output  1  sticky FIFO-overflow flag

Behaviour:
- Single clock `clk_in`; reset `rst_in` is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, all counters 0, FIFO empty.
- States:
  - IDLE: `start_in` latches base and count.
    - count != 0 -> RUN.
    - count == 0 -> DONE.
  - RUN: issues reads. -> DRAIN when issued == count.
  - DRAIN: waits for `in_flight` == 0, then -> DONE.
  - DONE: `done_out` = 1 for exactly one cycle, -> IDLE.
- `start_in` outside IDLE is ignored.
- Issue rule (RUN):
  - A read is issued in a cycle when issued < count and `in_flight` < FIFO_DEPTH.
  - `vtx_addr_out` = base + issued index, wraps modulo 2^ADDR_W.
  - Issued count increments and `in_flight` increments.
  - At most one issue per cycle; back-to-back issue is allowed.
- Read return:
  - A registered valid shift line of length READ_LATENCY tracks reads.
  - READ_LATENCY cycles after issue: `mm_valid_out` = 1 for one cycle, `mm_vec_out` = {32'h0001_0000, vtx_data_in}.
- Result capture:
  - `mm_valid_in` in RUN or DRAIN pushes `mm_vec_in` into the FIFO.
  - `mm_valid_in` in IDLE or DONE is discarded (stale results after reset).
  - Push while full: data dropped, `error_out` set to 1 until reset. Unreachable if `matrix_mult` is well-behaved.
- Output:
  - `out_valid_out` = FIFO not empty; `out_data_out` = FIFO head (first-word-fall-through).
  - A pop occurs on `out_valid_out` && `out_ready_in`; `in_flight` then decrements.
  - Issue and pop in the same cycle leave `in_flight` unchanged.
- `out_last_out`:
  - Asserted with the head entry when popped-count == count-1.
  - Held stable while stalled.
- `busy_out` = (state != IDLE).
- Reset mid-pass: aborts immediately, no `done_out`, FIFO flushed, `error_out` cleared.
- No arithmetic on data; w is constant 1.0.

Optional Feature:
- Macro: VERTEX_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output `stall_cnt_out` [31:0], which counts cycles with `out_valid_out`=1 && `out_ready_in`=0.
  - Counter clears on reset and on each accepted `start_in`; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic pass:
  - Stimulus: base=0x010, count=3, BRAM holds (1.0,2.0,3.0),(4,5,6),(7,8,9); `matrix_mult` model = identity with 4-cycle latency; `out_ready_in`=1.
  - Required: three outputs {0x00010000, z, y, x}, in order; `out_last_out` on the third only; `done_out` pulse one cycle after the last pop; `busy_out` low after that.
- Backpressure:
  - Stimulus: count=20, `out_ready_in`=0 for 100 cycles, then 1.
  - Required: exactly FIFO_DEPTH=8 reads issued while stalled; `error_out` stays 0; all 20 results delivered in order.
- Zero count:
  - Stimulus: start with count=0.
  - Required: no `vtx_addr_out` activity, no `mm_valid_out`; `done_out` pulses 2 cycles after `start_in`.
- Address wrap:
  - Stimulus: base=0xFFE, count=4.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-pass:
  - Stimulus: assert `rst_in` with 3 results outstanding; `matrix_mult` still returns them afterwards.
  - Required: FIFO stays empty, no `done_out`, `out_valid_out`=0; a new pass works normally.
- Overflow:
  - Stimulus: inject `mm_valid_in` pulses from a rogue model until the FIFO is full, plus one more.
  - Required: `error_out`=1 and stays set; FIFO contents are the first 8 entries.
